// File: rtl/alu_op_sequencer.sv
// ALU-control decoder with registered outputs and a latency
// counter that sequences multi-cycle multiply/divide operations.
module alu_op_sequencer #(
  parameter int FUNCT_W     = 4,
  parameter int OP_W        = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         ALUop,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               flush,
  output logic [OP_W-1:0]    operation,
  output logic               op_valid,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_done_s;

  logic [3:0]    w_code;
  logic          w_ill;
  logic          w_hi;
  logic          w_accept;
  logic          w_multi;
  logic [CW-1:0] w_lat_m1;

  assign w_hi = (funct >> 4) != '0;

  always_comb begin
    w_code = 4'd1;
    w_ill  = 1'b0;
    unique case (ALUop)
      2'b00: w_code = 4'd0;
      2'b01: w_code = 4'd9;
      2'b10: w_code = 4'd1;
      default: begin
        if (w_hi) begin
          w_ill = 1'b1;
        end else begin
          case (funct[3:0])
            4'b0000: w_code = 4'd1;
            4'b0010: w_code = 4'd2;
            4'b0100: w_code = 4'd3;
            4'b0101: w_code = 4'd4;
            4'b0111: w_code = 4'd5;
            4'b1000: w_code = 4'd6;
            4'b1010: w_code = 4'd7;
            4'b1011: w_code = 4'd8;
            default: w_ill  = 1'b1;
          endcase
        end
      end
    endcase
  end

  // Only mult/div with latency above one leave IDLE
  assign w_multi = ((w_code == 4'd3) && (MULT_CYCLES > 1)) ||
                   ((w_code == 4'd4) && (DIV_CYCLES > 1));
  assign w_lat_m1 = (w_code == 4'd3) ? CW'(MULT_CYCLES - 1) :
                                       CW'(DIV_CYCLES - 1);

  assign in_ready = (r_state == S_IDLE) && !reset;
  assign w_accept = in_valid && in_ready;

  // Flush or reset in the final busy cycle swallows the done pulse
  assign done = r_done_s |
                ((r_state == S_BUSY) && (r_cnt == '0) &&
                 !flush && !reset);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_done_s  <= 1'b0;
      operation <= OP_W'(1);
      op_valid  <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      illegal  <= 1'b0;
      r_done_s <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            operation <= OP_W'(w_code);
            op_valid  <= 1'b1;
            illegal   <= w_ill;
            if (w_multi) begin
              r_cnt   <= w_lat_m1;
              r_state <= S_BUSY;
              busy    <= 1'b1;
            end else begin
              r_done_s <= 1'b1;
            end
          end
        end
        default: begin
          if (flush || (r_cnt == '0)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus random checks of two alu_op_sequencer builds
// against a cycle-level behavioural model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] ALUop = 2'b00;
  logic [5:0] fb = '0;
  logic       flush = 1'b0;

  logic       a_rdy, a_opv, a_busy, a_done, a_ill;
  logic [3:0] a_op;
  logic       b_rdy, b_opv, b_busy, b_done, b_ill;
  logic [3:0] b_op;

  int nvec = 0;
  int nfail = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .FUNCT_W(4), .OP_W(4), .MULT_CYCLES(4), .DIV_CYCLES(8)
  ) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_ready(a_rdy), .ALUop(ALUop), .funct(fb[3:0]),
    .flush(flush), .operation(a_op), .op_valid(a_opv),
    .busy(a_busy), .done(a_done), .illegal(a_ill)
  );

  alu_op_sequencer #(
    .FUNCT_W(6), .OP_W(4), .MULT_CYCLES(1), .DIV_CYCLES(3)
  ) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_ready(b_rdy), .ALUop(ALUop), .funct(fb),
    .flush(flush), .operation(b_op), .op_valid(b_opv),
    .busy(b_busy), .done(b_done), .illegal(b_ill)
  );

  int mult_c [2] = '{4, 1};
  int div_c  [2] = '{8, 3};
  int fmask  [2] = '{15, 63};
  int tbl [16] = '{1, -1, 2, -1, 3, 4, -1, 5,
                   6, -1, 7, 8, -1, -1, -1, -1};

  // Model: cycles of busy left, and last issued outputs
  int m_rem [2];
  int m_op  [2];
  bit m_opv [2];
  bit m_ill [2];
  bit m_ds  [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_one(input int k, input logic rdy,
                           input logic [3:0] op, input logic opv,
                           input logic bsy, input logic dn,
                           input logic il);
    string p;
    bit exp_done;
    p = (k == 0) ? "A" : "B";
    exp_done = m_ds[k] ||
               (m_rem[k] == 1 && !flush && !reset);
    chk({p, ".in_ready"}, 32'(rdy), 32'(m_rem[k] == 0 && !reset));
    chk({p, ".operation"}, 32'(op), 32'(m_op[k]));
    chk({p, ".op_valid"}, 32'(opv), 32'(m_opv[k]));
    chk({p, ".busy"}, 32'(bsy), 32'(m_rem[k] > 0));
    chk({p, ".done"}, 32'(dn), 32'(exp_done));
    chk({p, ".illegal"}, 32'(il), 32'(m_ill[k]));
  endtask

  task automatic model_edge(input int k);
    int f;
    int code;
    bit ill;
    int lat;
    if (reset) begin
      m_rem[k] = 0; m_op[k] = 1;
      m_opv[k] = 0; m_ill[k] = 0; m_ds[k] = 0;
    end else if (m_rem[k] > 0) begin
      m_rem[k] = flush ? 0 : m_rem[k] - 1;
      m_opv[k] = 0; m_ill[k] = 0; m_ds[k] = 0;
    end else if (in_valid) begin
      f = int'(fb) & fmask[k];
      ill = 0;
      case (ALUop)
        2'b00: code = 0;
        2'b01: code = 9;
        2'b10: code = 1;
        default: begin
          if (f > 15 || tbl[f] < 0) begin
            code = 1; ill = 1;
          end else begin
            code = tbl[f];
          end
        end
      endcase
      lat = (code == 3) ? mult_c[k] :
            (code == 4) ? div_c[k] : 1;
      m_op[k] = code; m_opv[k] = 1; m_ill[k] = ill;
      if (lat > 1) begin
        m_rem[k] = lat; m_ds[k] = 0;
      end else begin
        m_ds[k] = 1;
      end
    end else begin
      m_opv[k] = 0; m_ill[k] = 0; m_ds[k] = 0;
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] op,
                     input logic [5:0] f, input logic fl,
                     input logic rs);
    @(negedge clk);
    in_valid = v; ALUop = op; fb = f; flush = fl; reset = rs;
    #1;
    if (armed) begin
      check_one(0, a_rdy, a_op, a_opv, a_busy, a_done, a_ill);
      check_one(1, b_rdy, b_op, b_opv, b_busy, b_done, b_ill);
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    armed = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 6'd0, 0, 0);
  endtask

  logic [5:0] codes [8] = '{6'h0, 6'h2, 6'h4, 6'h5,
                            6'h7, 6'h8, 6'hA, 6'hB};

  initial begin
    cyc(0, 2'b00, 6'd0, 0, 1);
    cyc(0, 2'b00, 6'd0, 0, 1);
    // Every legal funct, with idle gaps covering mult/div latency
    for (int i = 0; i < 8; i++) begin
      cyc(1, 2'b11, codes[i], 0, 0);
      idle(8);
    end
    cyc(1, 2'b00, 6'd0, 0, 0);
    cyc(1, 2'b01, 6'd0, 0, 0);
    cyc(1, 2'b10, 6'd0, 0, 0);
    cyc(1, 2'b11, 6'h7, 0, 0);
    cyc(1, 2'b11, 6'h8, 0, 0);
    idle(1);
    // Mult with in_valid pulses during busy
    cyc(1, 2'b11, 6'h4, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 2'b10, 6'd0, 0, 0);
    idle(2);
    // Illegal funct values
    cyc(1, 2'b11, 6'h0F, 0, 0);
    cyc(1, 2'b11, 6'h10, 0, 0);
    idle(2);
    // Div flushed in cycle 3
    cyc(1, 2'b11, 6'h5, 0, 0);
    idle(2);
    cyc(0, 2'b00, 6'd0, 1, 0);
    idle(9);
    // Flush in the final busy cycle of mult
    cyc(1, 2'b11, 6'h4, 0, 0);
    idle(3);
    cyc(0, 2'b00, 6'd0, 1, 0);
    idle(2);
    // Reset in cycle 2 of mult
    cyc(1, 2'b11, 6'h4, 0, 0);
    idle(1);
    cyc(0, 2'b00, 6'd0, 0, 1);
    idle(2);
    // Flush together with reset during div
    cyc(1, 2'b11, 6'h5, 0, 0);
    idle(1);
    cyc(1, 2'b11, 6'h5, 1, 1);
    idle(2);
    // Flush in IDLE does not block an accept
    cyc(1, 2'b11, 6'h7, 1, 0);
    cyc(1, 2'b11, 6'hA, 1, 0);
    idle(1);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] rf;
      rf = ($urandom_range(0, 3) == 0) ?
           6'($urandom) : codes[$urandom_range(0, 7)];
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), rf,
          1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 39) == 0));
    end
    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
